// File: rtl/rv_instr_encoder_if.sv
// Request/response bus of rv_instr_encoder.
//   in_*  : decoded instruction fields with a valid/ready handshake (loader -> encoder)
//   out_* : encoded word plus its word address with valid/ready (encoder -> instruction memory)
// Modports: slave = encoder side, master = loader/memory environment side.
interface rv_instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded instruction fields into RV32I words, tags each
// with a sequential instruction-memory word address and buffers them in a FIFO.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : rv_instr_encoder_if.slave (request in, encoded word out)
//   base_load   : one-cycle strobe loading the address counter from base_addr
//   base_addr   : start word address
//   err         : one-cycle pulse after a rejected request
//   count       : FIFO occupancy
// Optional feature: define IMM_RANGE_CHECK_EN to reject immediates that do not fit
// their instruction format; otherwise immediates are silently truncated.
module rv_instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rv_instr_encoder_if.slave         bus,
  input  logic                      base_load,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic                      err,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt_next;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_base;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [31:0]        enc_word;
  logic               enc_illegal;
  logic               imm_bad;
  logic               reject;
  logic               accept;
  logic               push;
  logic               pop;

  // Field packing per instruction class.
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (bus.in_class)
      3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_R};
      3'd1: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_I};
      3'd2: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      3'd3: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_imm[4:0], OP_STORE};
      3'd4: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
      3'd5: enc_word = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
      3'd6: enc_word = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
      default: enc_illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be exactly representable in the target format.
  always_comb begin
    imm_bad = 1'b0;
    case (bus.in_class)
      3'd1, 3'd2, 3'd3: imm_bad = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      3'd4:             imm_bad = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]))
                                  || bus.in_imm[0];
      3'd5, 3'd6:       imm_bad = |bus.in_imm[11:0];
      default:          imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign reject    = enc_illegal | imm_bad;
  assign accept    = bus.in_valid && in_ready_q;
  assign push      = accept && !reject;
  assign pop       = out_valid_q && bus.out_ready;
  // A base_load in the same cycle as a push addresses that word from base_addr.
  assign addr_base = base_load ? base_addr : addr_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_next = count;
    if (push && !pop) begin
      cnt_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_next = count - CNT_W'(1);
    end
  end

  // FIFO storage and pointers; reset clears contents so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: enc_word, addr: addr_base};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Address counter, occupancy, handshake flags and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err         <= 1'b0;
    end else begin
      addr_q      <= push ? addr_base + ADDR_W'(1) : addr_base;
      count       <= cnt_next;
      in_ready_q  <= (cnt_next != CNT_W'(DEPTH));
      out_valid_q <= (cnt_next != '0);
      err         <= accept && reject;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = mem[rd_ptr].instr;
  assign bus.out_addr  = mem[rd_ptr].addr;

endmodule
